lbp_hist: RTL and testbench

- Downstream consumer of the LBP stage: snoops the LBP result write stream (`lbp_valid` / `lbp_addr` / `lbp_data`) and builds a 256-bin histogram of LBP codes for a 128x128 image.
- When the LBP stage asserts `finish`, the block dumps all bins, in bin order, over a valid/ready stream to the feature-extraction host, then raises `hist_done`.

---
 rtl/lbp_hist.sv | 179 +++++++++++++++++
 tb/tb_lbp_hist.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// lbp_hist: snoops the LBP result write stream, builds a 256-bin histogram of
// LBP codes for a 128x128 image, then dumps the bins in order over a
// valid/ready stream once the LBP stage signals finish.
// Optional build macro: HIST_SKIP_ZERO_EN -- when defined, zero-count bins are
// scanned silently (hist_valid=0) and only non-zero bins are presented.
module lbp_hist #(
    parameter int unsigned CNT_W      = 14,
    parameter int unsigned IMG_W_LOG2 = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*IMG_W_LOG2-1:0]   lbp_addr,
    input  logic                      lbp_valid,
    input  logic [7:0]                lbp_data,
    input  logic                      finish,
    output logic                      hist_valid,
    input  logic                      hist_ready,
    output logic [7:0]                hist_bin,
    output logic [CNT_W-1:0]          hist_cnt,
    output logic                      hist_done,
    output logic [CNT_W-1:0]          pix_cnt,
    output logic                      addr_err
);

    localparam int unsigned ADDR_W = 2 * IMG_W_LOG2;
    localparam int unsigned NBINS  = 256;
    localparam logic [IMG_W_LOG2-1:0] EDGE_MAX = '1;
    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
    localparam logic [7:0]            LAST_BIN = 8'hFF;

`ifdef HIST_SKIP_ZERO_EN
    localparam logic SKIP_ZERO = 1'b1;
`else
    localparam logic SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DRAIN = 3'd2,
        S_DUMP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] bins_q [NBINS];

    logic             hist_valid_q, hist_valid_d;
    logic [7:0]       hist_bin_q,   hist_bin_d;
    logic [CNT_W-1:0] hist_cnt_q,   hist_cnt_d;
    logic             hist_done_q,  hist_done_d;
    logic [CNT_W-1:0] pix_cnt_q,    pix_cnt_d;
    logic             addr_err_q,   addr_err_d;

    logic [IMG_W_LOG2-1:0] row_c;
    logic [IMG_W_LOG2-1:0] col_c;
    logic                  border_c;
    logic                  accum_hit_c;
    logic                  count_en_c;
    logic [CNT_W-1:0]      hit_cnt_c;
    logic [CNT_W-1:0]      hit_cnt_inc_c;
    logic [7:0]            next_bin_c;
    logic [CNT_W-1:0]      next_cnt_c;
    logic [CNT_W-1:0]      first_cnt_c;
    logic                  advance_c;

    // Border detection and saturating increment of the addressed bin
    always_comb begin
        row_c         = lbp_addr[ADDR_W-1:IMG_W_LOG2];
        col_c         = lbp_addr[IMG_W_LOG2-1:0];
        border_c      = (row_c == '0) || (row_c == EDGE_MAX) ||
                        (col_c == '0) || (col_c == EDGE_MAX);
        accum_hit_c   = (state_q == S_ACCUM) && lbp_valid;
        count_en_c    = accum_hit_c && !border_c;
        hit_cnt_c     = bins_q[lbp_data];
        hit_cnt_inc_c = (hit_cnt_c == CNT_MAX) ? hit_cnt_c : hit_cnt_c + CNT_W'(1);
        next_bin_c    = hist_bin_q + 8'd1;
        next_cnt_c    = bins_q[next_bin_c];
        first_cnt_c   = bins_q[0];
        // A silent (skipped) bin always advances; a presented bin waits for ready
        advance_c     = hist_valid_q ? hist_ready : 1'b1;
    end

    // Histogram storage: one read-modify-write per cycle, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NBINS); i++) begin
                bins_q[i] <= '0;
            end
        end else if (count_en_c) begin
            bins_q[lbp_data] <= hit_cnt_inc_c;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        hist_valid_d = hist_valid_q;
        hist_bin_d   = hist_bin_q;
        hist_cnt_d   = hist_cnt_q;
        hist_done_d  = hist_done_q;
        pix_cnt_d    = pix_cnt_q;
        addr_err_d   = addr_err_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (lbp_valid) begin
                    if (border_c) begin
                        addr_err_d = 1'b1;
                    end else if (pix_cnt_q != CNT_MAX) begin
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
                if (finish) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last accumulated strobe is now visible in bins_q
                state_d      = S_DUMP;
                hist_bin_d   = 8'd0;
                hist_cnt_d   = first_cnt_c;
                hist_valid_d = !SKIP_ZERO || (first_cnt_c != '0);
            end
            S_DUMP: begin
                if (advance_c) begin
                    if (hist_bin_q == LAST_BIN) begin
                        hist_valid_d = 1'b0;
                        hist_done_d  = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        hist_bin_d   = next_bin_c;
                        hist_cnt_d   = next_cnt_c;
                        hist_valid_d = !SKIP_ZERO || (next_cnt_c != '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= 8'd0;
            hist_cnt_q   <= '0;
            hist_done_q  <= 1'b0;
            pix_cnt_q    <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_cnt_q   <= hist_cnt_d;
            hist_done_q  <= hist_done_d;
            pix_cnt_q    <= pix_cnt_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign hist_cnt   = hist_cnt_q;
    assign hist_done  = hist_done_q;
    assign pix_cnt    = pix_cnt_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Testbench for lbp_hist: random and directed LBP strobes checked against a
// histogram model; dumps are checked beat by beat for order, hold and count.
module tb_lbp_hist;

    localparam int CNT_W   = 14;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [13:0]       lbp_addr;
    logic              lbp_valid;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [7:0]        hist_bin;
    logic [CNT_W-1:0]  hist_cnt;
    logic              hist_done;
    logic [CNT_W-1:0]  pix_cnt;
    logic              addr_err;

    int n_tests = 0;
    int n_fail  = 0;

    int model_bins [256];
    int model_pix;
    bit model_err;

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_cnt   (hist_cnt),
        .hist_done  (hist_done),
        .pix_cnt    (pix_cnt),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model_bins[i] = 0;
        model_pix = 0;
        model_err = 0;
    endfunction

    // Next bin index the dump is expected to present, starting at 'from'
    function automatic int next_exp(input int from);
`ifdef HIST_SKIP_ZERO_EN
        for (int i = from; i < 256; i++) begin
            if (model_bins[i] != 0) return i;
        end
        return 256;
`else
        return from;
`endif
    endfunction

    function automatic int expected_beats();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
`ifdef HIST_SKIP_ZERO_EN
            if (model_bins[i] != 0) n++;
`else
            n++;
`endif
        end
        return n;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One strobe in the current cycle (called at a negedge), model updated by rule
    task automatic strobe(input logic [13:0] a, input logic [7:0] d);
        int r, c;
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        r = int'(a[13:7]);
        c = int'(a[6:0]);
        if (r == 0 || r == 127 || c == 0 || c == 127) begin
            model_err = 1;
        end else begin
            if (model_bins[d] < CNT_MAX) model_bins[d]++;
            if (model_pix < CNT_MAX) model_pix++;
        end
        @(negedge clk);
    endtask

    // Collect a dump; mode 0: ready high, 1: random ready plus junk strobes, 2: 1,0,0,1 pattern
    task automatic run_dump(input int mode);
        int  exp_bin, beats, cyc, pat, want;
        bit  seen, rdy;
        exp_bin = next_exp(0);
        want    = expected_beats();
        beats   = 0;
        cyc     = 0;
        pat     = 0;
        seen    = 0;
        if (mode == 0) hist_ready = 1'b1;
        while (!hist_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mode == 1) begin
                lbp_valid = 1'($urandom_range(0, 1));
                lbp_addr  = 14'($urandom);
                lbp_data  = 8'($urandom);
            end
            if (hist_done) break;
            if (hist_valid) begin
                seen = 1;
                n_tests++;
                if (exp_bin > 255) begin
                    n_fail++;
                    $display("FAIL dump_extra_beat: got bin %0d, required no further beat", hist_bin);
                end else if (hist_bin !== 8'(exp_bin) || hist_cnt !== 14'(model_bins[exp_bin])) begin
                    n_fail++;
                    $display("FAIL dump_beat: got bin %0d cnt %0d, required bin %0d cnt %0d",
                             hist_bin, hist_cnt, exp_bin, model_bins[exp_bin]);
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = ((pat % 4) == 0) || ((pat % 4) == 3);
                endcase
                pat++;
                hist_ready = rdy;
                if (rdy) begin
                    beats++;
                    exp_bin = next_exp(exp_bin + 1);
                end
            end else begin
`ifndef HIST_SKIP_ZERO_EN
                if (mode == 0 && seen) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dump_gap: got hist_valid 0 before bin %0d, required 1", exp_bin);
                end
`endif
            end
        end
        lbp_valid = 1'b0;
        n_tests++;
        if (!hist_done) begin
            n_fail++;
            $display("FAIL dump_timeout: got hist_done 0 after %0d cycles, required 1", cyc);
        end
        n_tests++;
        if (beats != want || exp_bin != 256) begin
            n_fail++;
            $display("FAIL dump_beats: got %0d beats (next bin %0d), required %0d beats", beats, exp_bin, want);
        end
        n_tests++;
        if (hist_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_valid: got %0b, required 0", hist_valid);
        end
        n_tests++;
        if (pix_cnt !== 14'(model_pix)) begin
            n_fail++;
            $display("FAIL dump_pix_cnt: got %0d, required %0d", pix_cnt, model_pix);
        end
        n_tests++;
        if (addr_err !== model_err) begin
            n_fail++;
            $display("FAIL dump_addr_err: got %0b, required %0b", addr_err, model_err);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({hist_valid, hist_done, addr_err} !== 3'b000 || hist_bin !== 8'd0 ||
            hist_cnt !== '0 || pix_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%0b d%0b e%0b bin%0d cnt%0d pix%0d, required all 0",
                     hist_valid, hist_done, addr_err, hist_bin, hist_cnt, pix_cnt);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (hist_valid !== 1'b0 || hist_done !== 1'b0 || pix_cnt !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v%0b d%0b pix%0d, required 0 0 0",
                     hist_valid, hist_done, pix_cnt);
        end
    endtask

    task automatic test_full_image();
        apply_reset();
        for (int r = 1; r <= 126; r++) begin
            for (int c = 1; c <= 126; c++) begin
                strobe({7'(r), 7'(c)}, 8'h00);
            end
        end
        lbp_valid = 1'b0;
        n_tests++;
        if (pix_cnt !== 14'd15876) begin
            n_fail++;
            $display("FAIL full_pix_cnt: got %0d, required 15876", pix_cnt);
        end
        finish = 1'b1;
        run_dump(0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        strobe(14'd129, 8'h5A);
        strobe(14'd130, 8'h5A);
        finish = 1'b1;
        strobe(14'd131, 8'h5A);
        lbp_valid = 1'b0;
        n_tests++;
        if (pix_cnt !== 14'd3) begin
            n_fail++;
            $display("FAIL b2b_pix_cnt: got %0d, required 3", pix_cnt);
        end
        run_dump(0);
        // Strobes and ready after completion are ignored
        lbp_valid  = 1'b1;
        lbp_addr   = 14'd0;
        lbp_data   = 8'h11;
        hist_ready = 1'b1;
        @(negedge clk);
        lbp_addr   = 14'd200;
        hist_ready = 1'b0;
        @(negedge clk);
        lbp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pix_cnt !== 14'd3 || addr_err !== 1'b0 || hist_done !== 1'b1 || hist_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ignores: got pix%0d err%0b done%0b v%0b, required 3 0 1 0",
                     pix_cnt, addr_err, hist_done, hist_valid);
        end
    endtask

    task automatic test_border();
        apply_reset();
        strobe(14'd0, 8'h10);
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL border_row0: got addr_err %0b, required 1", addr_err);
        end
        strobe(14'd127, 8'h10);
        strobe(14'd16256, 8'h10);
        lbp_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pix_cnt !== 14'd0 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL border_not_counted: got pix%0d err%0b, required 0 1", pix_cnt, addr_err);
        end
        strobe(14'd300, 8'h33);
        lbp_valid = 1'b0;
        n_tests++;
        if (pix_cnt !== 14'd1 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL border_sticky: got pix%0d err%0b, required 1 1", pix_cnt, addr_err);
        end
        finish = 1'b1;
        run_dump(1);
    endtask

    task automatic test_backpressure();
        logic [13:0] a;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            a = {7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))};
            strobe(a, 8'($urandom));
        end
        lbp_valid = 1'b0;
        finish    = 1'b1;
        run_dump(2);
    endtask

    task automatic test_random();
        logic [13:0] a;
        logic [7:0]  d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                lbp_valid = 1'b0;
                @(negedge clk);
            end
            if ($urandom_range(0, 9) == 0) a = 14'($urandom) & 14'h3F80;  // col 0
            else                           a = 14'($urandom);
            if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 3));
            else                           d = 8'($urandom);
            strobe(a, d);
        end
        lbp_valid = 1'b0;
        n_tests++;
        if (pix_cnt !== 14'(model_pix) || addr_err !== model_err) begin
            n_fail++;
            $display("FAIL random_accum: got pix%0d err%0b, required %0d %0b",
                     pix_cnt, addr_err, model_pix, model_err);
        end
        finish = 1'b1;
        run_dump(1);
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        apply_reset();
        for (int i = 0; i < 120; i++) begin
            strobe({7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))}, 8'($urandom));
        end
        lbp_valid  = 1'b0;
        hist_ready = 1'b1;
        finish     = 1'b1;
        cyc = 0;
        while (!(hist_valid && hist_bin == 8'd100) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc >= 1000) begin
            n_fail++;
            $display("FAIL mid_dump_reach: got no bin 100 within %0d cycles, required bin 100", cyc);
        end
        reset      = 1'b0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (hist_valid !== 1'b0 || hist_bin !== 8'd0 || pix_cnt !== '0 || hist_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_dump_async_reset: got v%0b bin%0d pix%0d d%0b, required 0 0 0 0",
                     hist_valid, hist_bin, pix_cnt, hist_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        strobe(14'd129, 8'hFF);
        lbp_valid = 1'b0;
        finish    = 1'b1;
        run_dump(0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_border();
        test_backpressure();
        test_random();
        test_reset_mid_dump();
        test_full_image();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
